// File: rtl/msg_checker.sv
// msg_checker: scans the decrypted-message RAM and reports whether every byte is 'a'-'z' or space.
//   clk, reset_n (async, active-low), start; read_decrypt_data is RAM data for address_d;
//   busy (not IDLE), finished (1-cycle verdict pulse), valid (whole message legal),
//   bad_index (first illegal address), good_count (legal bytes seen, MSG_LEN on pass).
module msg_checker #(
  parameter int MSG_LEN = 32,
  parameter int RD_LAT  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] read_decrypt_data,
  output logic [7:0] address_d,
  output logic       busy,
  output logic       finished,
  output logic       valid,
  output logic [7:0] bad_index,
  output logic [8:0] good_count
);
  localparam int WW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  typedef enum logic [2:0] {IDLE, SET_ADDR, WAIT, CHECK, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] idx;
  logic [WW-1:0] wcnt;
  logic legal, last, wait_end;
  assign legal    = read_decrypt_data == 8'h20 ||
                    (read_decrypt_data >= 8'h61 && read_decrypt_data <= 8'h7A);
  assign last     = idx == 8'(MSG_LEN - 1);
  assign wait_end = wcnt == WW'(RD_LAT - 1);
  assign busy     = state != IDLE;
  assign finished = state == DONE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = start ? SET_ADDR : IDLE;
      SET_ADDR: state_nx = WAIT;
      WAIT:     state_nx = wait_end ? CHECK : WAIT;
      CHECK:    state_nx = (!legal || last) ? DONE : SET_ADDR;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      address_d  <= '0;
      bad_index  <= '0;
      good_count <= '0;
      idx        <= '0;
      wcnt       <= '0;
      valid      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          idx        <= '0;
          valid      <= 1'b0;
          bad_index  <= '0;
          good_count <= '0;
        end
        SET_ADDR: begin
          address_d <= idx;
          wcnt      <= '0;
        end
        WAIT: wcnt <= wcnt + 1'b1;
        CHECK: if (!legal) begin
          bad_index <= idx;
          valid     <= 1'b0;
        end else begin
          good_count <= good_count + 9'd1;
          if (last) valid <= 1'b1;
          else idx <= idx + 8'd1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_msg_checker.sv
// tb_msg_checker: scoreboard bench for msg_checker with a two-stage pipelined RAM model.
module tb_msg_checker;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] read_decrypt_data;
  logic [7:0] address_d;
  logic       busy, finished, valid;
  logic [7:0] bad_index;
  logic [8:0] good_count;
  logic [7:0] mem [256];
  logic [7:0] p1, p2;
  typedef struct {
    logic       v;
    logic [7:0] bi;
    logic [8:0] gc;
    int         cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int vec = 0;
  int errs = 0;
  int cyc, amax;

  msg_checker #(.MSG_LEN(32), .RD_LAT(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .read_decrypt_data(read_decrypt_data), .address_d(address_d),
    .busy(busy), .finished(finished), .valid(valid),
    .bad_index(bad_index), .good_count(good_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    p1 <= mem[address_d];
    p2 <= p1;
  end
  assign read_decrypt_data = p2;

  task automatic fill(input logic [7:0] b);
    for (int i = 0; i < 256; i++) mem[i] = b;
  endtask

  task automatic launch();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called at cycle 1 after the start edge; returns the cycle finished is seen (-1 on timeout)
  // and the highest address presented from cycle 2 on.
  task automatic wait_done(input int restart_at, output int c, output int amx);
    c = 1;
    amx = 0;
    while (!finished && c < 400) begin
      if (c == restart_at) start = 1'b1;
      else if (c == restart_at + 1) start = 1'b0;
      @(posedge clk);
      #1 c++;
      if (address_d > amx[7:0]) amx = int'(address_d);
    end
    if (!finished) c = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    vec++;
    if ({busy, finished, valid, bad_index, good_count, address_d} !== 27'd0) begin
      errs++;
      $display("FAIL reset outputs got busy=%b fin=%b v=%b bi=%0d gc=%0d ad=%0d want all 0",
               busy, finished, valid, bad_index, good_count, address_d);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_pass();
    fill(8'h61);
    sb.push_back('{1'b1, 8'd0, 9'd32, 129});
    launch();
    wait_done(-1, cyc, amax);
    e = sb.pop_front();
    vec++;
    if (cyc !== e.cyc) begin
      errs++;
      $display("FAIL full_pass cycle got %0d want %0d", cyc, e.cyc);
    end
    vec++;
    if ({valid, bad_index, good_count} !== {e.v, e.bi, e.gc}) begin
      errs++;
      $display("FAIL full_pass result got v=%b bi=%0d gc=%0d want v=%b bi=%0d gc=%0d",
               valid, bad_index, good_count, e.v, e.bi, e.gc);
    end
    @(posedge clk);
    #1;
    vec++;
    if ({finished, busy, valid, good_count} !== {1'b0, 1'b0, 1'b1, 9'd32}) begin
      errs++;
      $display("FAIL full_pass after got fin=%b busy=%b v=%b gc=%0d want fin=0 busy=0 v=1 gc=32",
               finished, busy, valid, good_count);
    end
  endtask

  task automatic test_early_abort();
    fill(8'h61);
    mem[5] = 8'h41;
    sb.push_back('{1'b0, 8'd5, 9'd5, 25});
    launch();
    wait_done(-1, cyc, amax);
    e = sb.pop_front();
    vec++;
    if (cyc !== e.cyc) begin
      errs++;
      $display("FAIL early_abort cycle got %0d want %0d", cyc, e.cyc);
    end
    vec++;
    if ({valid, bad_index, good_count} !== {e.v, e.bi, e.gc}) begin
      errs++;
      $display("FAIL early_abort result got v=%b bi=%0d gc=%0d want v=%b bi=%0d gc=%0d",
               valid, bad_index, good_count, e.v, e.bi, e.gc);
    end
    vec++;
    if (amax !== 5) begin
      errs++;
      $display("FAIL early_abort max address got %0d want 5", amax);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_char_bounds();
    logic [7:0] vals [7];
    logic       ok [7];
    vals = '{8'h20, 8'h61, 8'h7A, 8'h1F, 8'h60, 8'h7B, 8'hE1};
    ok   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      fill(8'h20);
      mem[0] = vals[i];
      if (ok[i]) sb.push_back('{1'b1, 8'd0, 9'd32, 129});
      else sb.push_back('{1'b0, 8'd0, 9'd0, 5});
      launch();
      wait_done(-1, cyc, amax);
      e = sb.pop_front();
      vec++;
      if (cyc !== e.cyc) begin
        errs++;
        $display("FAIL char_%h cycle got %0d want %0d", vals[i], cyc, e.cyc);
      end
      vec++;
      if ({valid, bad_index, good_count} !== {e.v, e.bi, e.gc}) begin
        errs++;
        $display("FAIL char_%h result got v=%b bi=%0d gc=%0d want v=%b bi=%0d gc=%0d",
                 vals[i], valid, bad_index, good_count, e.v, e.bi, e.gc);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_last_byte();
    fill(8'h20);
    mem[31] = 8'h00;
    sb.push_back('{1'b0, 8'd31, 9'd31, 129});
    launch();
    wait_done(-1, cyc, amax);
    e = sb.pop_front();
    vec++;
    if (cyc !== e.cyc) begin
      errs++;
      $display("FAIL last_byte cycle got %0d want %0d", cyc, e.cyc);
    end
    vec++;
    if ({valid, bad_index, good_count} !== {e.v, e.bi, e.gc}) begin
      errs++;
      $display("FAIL last_byte result got v=%b bi=%0d gc=%0d want v=%b bi=%0d gc=%0d",
               valid, bad_index, good_count, e.v, e.bi, e.gc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_start_busy();
    fill(8'h7A);
    sb.push_back('{1'b1, 8'd0, 9'd32, 129});
    launch();
    wait_done(40, cyc, amax);
    e = sb.pop_front();
    vec++;
    if (cyc !== e.cyc) begin
      errs++;
      $display("FAIL start_busy cycle got %0d want %0d", cyc, e.cyc);
    end
    vec++;
    if ({valid, bad_index, good_count} !== {e.v, e.bi, e.gc}) begin
      errs++;
      $display("FAIL start_busy result got v=%b bi=%0d gc=%0d want v=%b bi=%0d gc=%0d",
               valid, bad_index, good_count, e.v, e.bi, e.gc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    fill(8'h61);
    launch();
    for (int c = 1; c < 60; c++) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    #1;
    vec++;
    if ({busy, finished, valid, bad_index, good_count, address_d} !== 27'd0) begin
      errs++;
      $display("FAIL reset_mid outputs got busy=%b fin=%b v=%b bi=%0d gc=%0d ad=%0d want all 0",
               busy, finished, valid, bad_index, good_count, address_d);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      vec++;
      if (finished !== 1'b0) begin
        errs++;
        $display("FAIL reset_mid finished got %b want 0", finished);
      end
    end
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid idle busy got %b want 0", busy);
    end
    sb.push_back('{1'b1, 8'd0, 9'd32, 129});
    launch();
    wait_done(-1, cyc, amax);
    e = sb.pop_front();
    vec++;
    if (cyc !== e.cyc) begin
      errs++;
      $display("FAIL reset_mid rerun cycle got %0d want %0d", cyc, e.cyc);
    end
    vec++;
    if ({valid, bad_index, good_count} !== {e.v, e.bi, e.gc}) begin
      errs++;
      $display("FAIL reset_mid rerun result got v=%b bi=%0d gc=%0d want v=%b bi=%0d gc=%0d",
               valid, bad_index, good_count, e.v, e.bi, e.gc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    fill(8'h61);
    mem[2] = 8'h7B;
    sb.push_back('{1'b0, 8'd2, 9'd2, 13});
    sb.push_back('{1'b1, 8'd0, 9'd32, 129});
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(-1, cyc, amax);
    e = sb.pop_front();
    vec++;
    if (cyc !== e.cyc || {valid, bad_index, good_count} !== {e.v, e.bi, e.gc}) begin
      errs++;
      $display("FAIL b2b first got cyc=%0d v=%b bi=%0d gc=%0d want cyc=%0d v=%b bi=%0d gc=%0d",
               cyc, valid, bad_index, good_count, e.cyc, e.v, e.bi, e.gc);
    end
    mem[2] = 8'h61;
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b0;
    vec++;
    if ({busy, valid, bad_index, good_count} !== {1'b1, 1'b0, 8'd0, 9'd0}) begin
      errs++;
      $display("FAIL b2b relaunch got busy=%b v=%b bi=%0d gc=%0d want busy=1 v=0 bi=0 gc=0",
               busy, valid, bad_index, good_count);
    end
    wait_done(-1, cyc, amax);
    e = sb.pop_front();
    vec++;
    if (cyc !== e.cyc || {valid, bad_index, good_count} !== {e.v, e.bi, e.gc}) begin
      errs++;
      $display("FAIL b2b second got cyc=%0d v=%b bi=%0d gc=%0d want cyc=%0d v=%b bi=%0d gc=%0d",
               cyc, valid, bad_index, good_count, e.cyc, e.v, e.bi, e.gc);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    fill(8'h00);
    test_reset();
    test_full_pass();
    test_early_abort();
    test_char_bounds();
    test_last_byte();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/msg_checker.md
# msg_checker

Reads back the plaintext the RC4 decrypt FSM writes into the decrypted-message RAM and decides whether it is a plausible message: every byte must be lowercase ASCII `a`–`z` (8'h61–8'h7A) or space (8'h20). It sits on the read port of the decrypted RAM, after the decrypt FSM in the key-search loop. It aborts on the first illegal byte so a wrong key is rejected early, and reports a pass/fail verdict, the failing index and the count of good bytes.

## Interface
- `MSG_LEN`, 32: message length in bytes, range 1–256; byte addresses run 0..MSG_LEN-1.
- `RD_LAT`, 2: wait cycles between driving `address_d` and sampling `read_decrypt_data`; must be ≥1.

- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch a check; sampled only in IDLE.
- `read_decrypt_data`  in  8  RAM read data for `address_d`.
- `address_d`  out  8  registered RAM read address.
- `busy`  out  1  high in every state except IDLE.
- `finished`  out  1  one-cycle pulse when the verdict is final.
- `valid`  out  1  1 means the whole message is legal; held until the next accepted start.
- `bad_index`  out  8  address of the first illegal byte; 0 when `valid`=1; held until the next accepted start.
- `good_count`  out  9  number of legal bytes seen before the abort, or MSG_LEN on pass.

## Operation
- States:
  - **IDLE**: when `start`=1, clear `idx`, `valid`, `bad_index` and `good_count`, then go to SET_ADDR. Otherwise stay in IDLE.
  - **SET_ADDR**: `address_d` <= `idx`; `wcnt` <= 0; go to WAIT.
  - **WAIT**: `wcnt` increments. When `wcnt`==RD_LAT-1, go to CHECK.
  - **CHECK**: sample `read_decrypt_data`.
    - Byte illegal: `bad_index` <= `idx`, `valid` <= 0, go to DONE.
    - Byte legal and `idx`==MSG_LEN-1: `good_count`++, `valid` <= 1, go to DONE.
    - Byte legal otherwise: `good_count`++, `idx`++, go to SET_ADDR.
  - **DONE**: `finished`=1 for this cycle only; go to IDLE.
- Legality test is combinational on the 8-bit byte: (b==8'h20) | (b≥8'h61 & b≤8'h7A). The MSB set always fails.
- `idx` is 8 bits. `good_count` is 9 bits so that MSG_LEN=256 reports 256. `idx` never wraps, because the check stops at MSG_LEN-1.
- `start` while `busy`=1 is ignored and does not restart the check.
- If `start` is still high in the IDLE cycle after DONE, a new check launches and clears the previous results.
- The block never writes the RAM and has no write-enable output.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - `address_d`, `bad_index`, `good_count`, `idx` and `wcnt` go to 0.
  - `valid`, `finished` and `busy` go to 0.
- Reset mid-check abandons the check. No `finished` pulse is produced. The block restarts only on a new `start` after release.
- Per byte: 1 (SET_ADDR) + RD_LAT (WAIT) + 1 (CHECK) = RD_LAT+2 cycles.
- Let E0 be the edge that samples `start` in IDLE.
  - Full pass: `finished` is high during cycle 1 + MSG_LEN·(RD_LAT+2) after E0, which is cycle 129 for the defaults.
  - Abort at index n: `finished` is high during cycle 1 + (n+1)·(RD_LAT+2) after E0.
- `address_d` changes only on the edge leaving SET_ADDR. The RAM therefore sees a stable address for RD_LAT+1 edges before CHECK samples.
- `valid`, `bad_index` and `good_count` are final on the same edge that raises `finished`, and stay stable while `busy`=0.
- Minimum start-to-start spacing is back-to-back through DONE→IDLE.

## Test plan
- **Full pass:** RAM holds 32×8'h61. Pulse start -> `finished` in cycle 129; `valid`=1, `good_count`=32, `bad_index`=0.
- **Early abort:** byte 5 = 8'h41 (`A`), the rest 8'h61 -> `finished` in cycle 25; `valid`=0, `bad_index`=5, `good_count`=5; addresses 6–31 are never driven.
- **Character boundaries:** one run per value at byte 0 (rest 8'h20).
  - 8'h20, 8'h61 and 8'h7A -> pass.
  - 8'h1F, 8'h60, 8'h7B and 8'hE1 -> `valid`=0, `bad_index`=0, `finished` in cycle 5.
- **Last byte:** byte 31 = 8'h00 -> `valid`=0, `bad_index`=31, `good_count`=31, `finished` in cycle 129.
- **Start while busy / reset mid-check:**
  - Re-pulse start at cycle 40 -> ignored; result is the same as the full-pass case.
  - Assert `reset_n`=0 at cycle 60 -> all outputs 0 immediately and no `finished` pulse; a new start then produces the full 129-cycle pass.
- **Back-to-back:** hold start high across two runs, the first with a bad byte 2, the second all legal -> first `finished` in cycle 13; results clear on re-launch; second `finished` 129 cycles after the second start edge with `valid`=1.
